// File: rtl/ast_dmx_dir_sched_if.sv
// Snooped Avalon-ST demux input handshake, shared by the beat source and the direction scheduler.
// Handshake: a beat transfers on every rising clock edge where ast_valid_i and ast_ready_i are both 1.
interface ast_dmx_dir_sched_if #(
  parameter int CHANNEL_W = 4
);
  logic                 ast_valid_i;
  logic                 ast_ready_i;
  logic                 ast_startofpacket_i;
  logic                 ast_endofpacket_i;
  logic [CHANNEL_W-1:0] ast_channel_i;

  modport master (
    output ast_valid_i, ast_ready_i, ast_startofpacket_i, ast_endofpacket_i, ast_channel_i
  );

  modport slave (
    input ast_valid_i, ast_ready_i, ast_startofpacket_i, ast_endofpacket_i, ast_channel_i
  );
endinterface

// File: rtl/ast_dmx_dir_sched.sv
// Per-packet direction scheduler: picks a demux direction at SOP (table or round-robin)
// and holds it until EOP, flagging completed packets and framing errors.
module ast_dmx_dir_sched #(
  parameter int CHANNEL_W     = 4,
  parameter int TX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = $clog2(TX_DIR)
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  ast_dmx_dir_sched_if.slave       ast,
  input  logic                     mode_i,
  input  logic                     cfg_wr_i,
  input  logic [CHANNEL_W-1:0]     cfg_addr_i,
  input  logic [DIR_SEL_WIDTH-1:0] cfg_dir_i,
  output logic [DIR_SEL_WIDTH-1:0] cfg_rd_data_o,
  output logic [DIR_SEL_WIDTH-1:0] dir_o,
  output logic                     busy_o,
  output logic                     pkt_done_o,
  output logic [DIR_SEL_WIDTH-1:0] pkt_dir_o,
  output logic                     err_o,
  output logic                     dbg_state_o
);
  localparam int                     DEPTH = 2 ** CHANNEL_W;
  localparam logic [DIR_SEL_WIDTH:0] TXD   = (DIR_SEL_WIDTH + 1)'(TX_DIR);
  localparam logic [DIR_SEL_WIDTH-1:0] LAST = DIR_SEL_WIDTH'(TX_DIR - 1);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [DIR_SEL_WIDTH-1:0] tbl_q [DEPTH];
  logic [DIR_SEL_WIDTH-1:0] rr_q, rr_d;
  logic [DIR_SEL_WIDTH-1:0] lock_q, lock_d;
  logic [DIR_SEL_WIDTH-1:0] pdir_q, pdir_d;
  logic [DIR_SEL_WIDTH-1:0] rd_q;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [DIR_SEL_WIDTH-1:0] next_dir;
  logic [DIR_SEL_WIDTH-1:0] rr_inc;
  logic [DIR_SEL_WIDTH-1:0] wr_dir;
  logic                     beat;

  assign beat     = ast.ast_valid_i & ast.ast_ready_i;
  assign next_dir = mode_i ? rr_q : tbl_q[ast.ast_channel_i];
  assign rr_inc   = (rr_q == LAST) ? '0 : rr_q + 1'b1;
  assign wr_dir   = ({1'b0, cfg_dir_i} >= TXD) ? LAST : cfg_dir_i;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    pdir_d  = pdir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (beat) begin
      if (ast.ast_startofpacket_i) begin
        // A SOP inside an open packet abandons it and restarts on the new beat.
        err_d = (state_q == PKT);
        if (ast.ast_endofpacket_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pdir_d  = next_dir;
          rr_d    = rr_inc;
        end else begin
          state_d = PKT;
          lock_d  = next_dir;
        end
      end else if (state_q == PKT) begin
        if (ast.ast_endofpacket_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pdir_d  = lock_q;
          rr_d    = rr_inc;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      pdir_q  <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= DIR_SEL_WIDTH'(i % TX_DIR);
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      pdir_q  <= pdir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= tbl_q[cfg_addr_i];
      if (cfg_wr_i) begin
        tbl_q[cfg_addr_i] <= wr_dir;
      end
    end
  end

  // A restarting SOP inside a packet is already routed on its own fresh direction.
  assign dir_o = (state_q == PKT && !(ast.ast_valid_i && ast.ast_startofpacket_i)) ? lock_q : next_dir;

  assign busy_o        = (state_q == PKT);
  assign pkt_done_o    = done_q;
  assign pkt_dir_o     = pdir_q;
  assign err_o         = err_q;
  assign cfg_rd_data_o = rd_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ast_dmx_dir_sched.sv
// Bench for ast_dmx_dir_sched: a 4-direction and a 3-direction instance snoop the same bus and
// are checked against a packet-level reference model, vector tables and hand sequences.
module tb_ast_dmx_dir_sched;
  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       mode = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [1:0] cfg_dir = '0;

  logic [1:0] d4_rd, d4_dir, d4_pdir, d3_rd, d3_dir, d3_pdir;
  logic       d4_busy, d4_done, d4_err, d4_st, d3_busy, d3_done, d3_err, d3_st;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: index 0 = 4-direction build, 1 = 3-direction build.
  int         m_tbl [2][16];
  int         m_rr [2];
  bit         m_open [2];
  int         m_lock [2];
  bit         e_done [2];
  bit         e_err [2];
  int         e_rd [2];
  logic [1:0] exp_q4[$];
  logic [1:0] exp_q3[$];

  ast_dmx_dir_sched_if #(.CHANNEL_W(4)) bus ();

  always #5 clk = ~clk;

  ast_dmx_dir_sched #(.CHANNEL_W(4), .TX_DIR(4)) u4 (
    .clk_i(clk), .arst_n_i(arst_n), .ast(bus.slave), .mode_i(mode), .cfg_wr_i(cfg_wr),
    .cfg_addr_i(cfg_addr), .cfg_dir_i(cfg_dir), .cfg_rd_data_o(d4_rd), .dir_o(d4_dir),
    .busy_o(d4_busy), .pkt_done_o(d4_done), .pkt_dir_o(d4_pdir), .err_o(d4_err),
    .dbg_state_o(d4_st)
  );

  ast_dmx_dir_sched #(.CHANNEL_W(4), .TX_DIR(3)) u3 (
    .clk_i(clk), .arst_n_i(arst_n), .ast(bus.slave), .mode_i(mode), .cfg_wr_i(cfg_wr),
    .cfg_addr_i(cfg_addr), .cfg_dir_i(cfg_dir), .cfg_rd_data_o(d3_rd), .dir_o(d3_dir),
    .busy_o(d3_busy), .pkt_done_o(d3_done), .pkt_dir_o(d3_pdir), .err_o(d3_err),
    .dbg_state_o(d3_st)
  );

  typedef struct {
    bit         rst;
    bit         v, r, s, e;
    logic [3:0] ch;
    bit         mode;
    int         dir4, dir3;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int tx_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int pick_dir(input int k);
    return mode ? m_rr[k] : m_tbl[k][bus.ast_channel_i];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_tbl[k][i] = i % tx_of(k);
      m_rr[k] = 0;
      m_open[k] = 1'b0;
      m_lock[k] = 0;
    end
    exp_q4.delete();
    exp_q3.delete();
  endtask

  task automatic complete(input int k, input int d);
    if (k == 0) exp_q4.push_back(2'(d));
    else exp_q3.push_back(2'(d));
    e_done[k] = 1'b1;
    m_rr[k] = (m_rr[k] + 1) % tx_of(k);
  endtask

  // One clock of packet-level behaviour for the current bus/config inputs.
  task automatic model_edge();
    int nd;
    for (int k = 0; k < 2; k++) begin
      nd = pick_dir(k);
      e_done[k] = 1'b0;
      e_err[k] = 1'b0;
      if (bus.ast_valid_i && bus.ast_ready_i) begin
        if (bus.ast_startofpacket_i) begin
          if (m_open[k]) e_err[k] = 1'b1;
          if (bus.ast_endofpacket_i) begin
            complete(k, nd);
            m_open[k] = 1'b0;
          end else begin
            m_open[k] = 1'b1;
            m_lock[k] = nd;
          end
        end else if (m_open[k]) begin
          if (bus.ast_endofpacket_i) begin
            complete(k, m_lock[k]);
            m_open[k] = 1'b0;
          end
        end else begin
          e_err[k] = 1'b1;
        end
      end
      e_rd[k] = m_tbl[k][cfg_addr];
      if (cfg_wr) m_tbl[k][cfg_addr] = (int'(cfg_dir) >= tx_of(k)) ? tx_of(k) - 1 : int'(cfg_dir);
    end
  endtask

  task automatic drive(input bit v, input bit r, input bit s, input bit e, input logic [3:0] ch,
                       input bit md, input bit wr, input logic [3:0] addr, input logic [1:0] cd);
    bus.ast_valid_i = v;
    bus.ast_ready_i = r;
    bus.ast_startofpacket_i = s;
    bus.ast_endofpacket_i = e;
    bus.ast_channel_i = ch;
    mode = md;
    cfg_wr = wr;
    cfg_addr = addr;
    cfg_dir = cd;
  endtask

  task automatic comb_chk();
    int ed;
    #2;
    for (int k = 0; k < 2; k++) begin
      ed = (m_open[k] && !(bus.ast_valid_i && bus.ast_startofpacket_i)) ? m_lock[k] : pick_dir(k);
      if (k == 0) begin
        chk("dir4", int'(d4_dir), ed);
        chk("busy4", int'(d4_busy), int'(m_open[0]));
      end else begin
        chk("dir3", int'(d3_dir), ed);
        chk("busy3", int'(d3_busy), int'(m_open[1]));
      end
    end
  endtask

  task automatic edge_chk();
    logic [1:0] ex;
    model_edge();
    @(posedge clk);
    #1;
    chk("done4", int'(d4_done), int'(e_done[0]));
    chk("err4", int'(d4_err), int'(e_err[0]));
    chk("rd4", int'(d4_rd), e_rd[0]);
    chk("done3", int'(d3_done), int'(e_done[1]));
    chk("err3", int'(d3_err), int'(e_err[1]));
    chk("rd3", int'(d3_rd), e_rd[1]);
    if (d4_done) begin
      ex = (exp_q4.size() > 0) ? exp_q4.pop_front() : 2'bxx;
      chk("pkt_dir4", int'(d4_pdir), int'(ex));
    end
    if (d3_done) begin
      ex = (exp_q3.size() > 0) ? exp_q3.pop_front() : 2'bxx;
      chk("pkt_dir3", int'(d3_pdir), int'(ex));
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy4", int'(d4_busy), 0);
    chk("rst_done4", int'(d4_done), 0);
    chk("rst_err4", int'(d4_err), 0);
    chk("rst_rd4", int'(d4_rd), 0);
    chk("rst_pdir4", int'(d4_pdir), 0);
    chk("rst_busy3", int'(d3_busy), 0);
    chk("rst_rd3", int'(d3_rd), 0);
    chk("rst_pdir3", int'(d3_pdir), 0);
    drive(0, 0, 0, 0, 4'd0, mode, 0, 4'd0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: chan 5 three-beat packet with two ready-low cycles; T2: seven round-robin singles.
    vecs[0]  = '{1, 1, 1, 1, 0, 4'd5, 0, 1, 2, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 4'd5, 0, 1, 2, 1, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 4'd5, 0, 1, 2, 1, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 4'd5, 0, 1, 2, 1, 0};
    vecs[4]  = '{0, 1, 1, 0, 1, 4'd5, 0, 1, 2, 1, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 4'd5, 0, 1, 2, 0, 0};
    vecs[6]  = '{1, 1, 1, 1, 1, 4'd9, 1, 0, 0, 0, 1};
    vecs[7]  = '{0, 1, 1, 1, 1, 4'd9, 1, 1, 1, 0, 1};
    vecs[8]  = '{0, 1, 1, 1, 1, 4'd9, 1, 2, 2, 0, 1};
    vecs[9]  = '{0, 1, 1, 1, 1, 4'd9, 1, 3, 0, 0, 1};
    vecs[10] = '{0, 1, 1, 1, 1, 4'd9, 1, 0, 1, 0, 1};
    vecs[11] = '{0, 1, 1, 1, 1, 4'd9, 1, 1, 2, 0, 1};
    vecs[12] = '{0, 1, 1, 1, 1, 4'd9, 1, 2, 0, 0, 1};

    drive(0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 2'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].v, vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].ch, vecs[i].mode, 0, 4'd0, 2'd0);
      comb_chk();
      chk($sformatf("vec%0d_dir4", i), int'(d4_dir), vecs[i].dir4);
      chk($sformatf("vec%0d_dir3", i), int'(d3_dir), vecs[i].dir3);
      chk($sformatf("vec%0d_busy", i), int'(d4_busy), int'(vecs[i].busy));
      edge_chk();
      chk($sformatf("vec%0d_done", i), int'(d4_done), int'(vecs[i].done));
    end

    // T3: write table[5] on the same cycle as a chan-5 SOP; old entry used, new one next packet.
    do_reset();
    drive(1, 1, 1, 1, 4'd5, 0, 1, 4'd5, 2'd3);
    comb_chk();
    chk("t3_old_dir4", int'(d4_dir), 1);
    edge_chk();
    drive(1, 1, 1, 1, 4'd5, 0, 0, 4'd5, 2'd0);
    comb_chk();
    chk("t3_new_dir4", int'(d4_dir), 3);
    chk("t3_clamp_dir3", int'(d3_dir), 2);
    edge_chk();
    chk("t3_rd4", int'(d4_rd), 3);
    chk("t3_rd3_clamped", int'(d3_rd), 2);

    // T4: SOP inside a packet, then a stray non-SOP beat in IDLE; rr only counts one packet.
    do_reset();
    drive(1, 1, 1, 0, 4'd2, 0, 0, 4'd0, 2'd0);
    comb_chk();
    edge_chk();
    drive(1, 1, 1, 0, 4'd1, 0, 0, 4'd0, 2'd0);
    comb_chk();
    chk("t4_relock_dir4", int'(d4_dir), 1);
    edge_chk();
    chk("t4_err4", int'(d4_err), 1);
    chk("t4_nodone4", int'(d4_done), 0);
    drive(1, 1, 0, 1, 4'd1, 0, 0, 4'd0, 2'd0);
    comb_chk();
    edge_chk();
    chk("t4_done4", int'(d4_done), 1);
    drive(1, 1, 0, 1, 4'd7, 0, 0, 4'd0, 2'd0);
    comb_chk();
    edge_chk();
    chk("t4_stray_err4", int'(d4_err), 1);
    drive(1, 1, 1, 1, 4'd0, 1, 0, 4'd0, 2'd0);
    comb_chk();
    chk("t4_rr_dir4", int'(d4_dir), 1);
    chk("t4_rr_dir3", int'(d3_dir), 1);
    edge_chk();

    // T5: mode flip and table rewrite mid-packet leave the locked direction alone.
    do_reset();
    drive(1, 1, 1, 0, 4'd5, 0, 0, 4'd0, 2'd0);
    comb_chk();
    edge_chk();
    drive(0, 1, 0, 0, 4'd5, 1, 1, 4'd5, 2'd0);
    comb_chk();
    chk("t5_hold_dir4", int'(d4_dir), 1);
    edge_chk();
    drive(1, 1, 0, 0, 4'd5, 1, 0, 4'd0, 2'd0);
    comb_chk();
    chk("t5_mid_dir4", int'(d4_dir), 1);
    edge_chk();
    drive(1, 1, 0, 1, 4'd5, 0, 0, 4'd0, 2'd0);
    comb_chk();
    chk("t5_eop_dir4", int'(d4_dir), 1);
    edge_chk();
    chk("t5_pdir4", int'(d4_pdir), 1);

    // T6: asynchronous reset in the middle of a packet, then table/rr back to defaults.
    drive(0, 0, 0, 0, 4'd6, 0, 1, 4'd6, 2'd1);
    comb_chk();
    edge_chk();
    drive(1, 1, 1, 0, 4'd6, 0, 0, 4'd0, 2'd0);
    comb_chk();
    chk("t6_sop_dir4", int'(d4_dir), 1);
    edge_chk();
    drive(0, 0, 0, 0, 4'd6, 0, 0, 4'd0, 2'd0);
    #1;
    arst_n = 1'b0;
    #1;
    chk("t6_busy4", int'(d4_busy), 0);
    chk("t6_dir4", int'(d4_dir), 2);
    chk("t6_dir3", int'(d3_dir), 0);
    do_reset();
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 4'd0, 1, 0, 4'(a), 2'd0);
      comb_chk();
      edge_chk();
    end
    drive(1, 1, 1, 1, 4'd3, 1, 0, 4'd0, 2'd0);
    comb_chk();
    chk("t6_rr0_dir4", int'(d4_dir), 0);
    edge_chk();

    // Randomized traffic with occasional config writes and mode flips.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? !mode : mode, $urandom_range(0, 5) == 0,
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      comb_chk();
      edge_chk();
    end
    drive(0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 2'd0);
    comb_chk();
    edge_chk();

    chk("q4_drained", exp_q4.size(), 0);
    chk("q3_drained", exp_q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
